// File: rtl/adc_capture_writer_pkg.sv
// Shared codec definitions: sample format, buffer geometry, writer FSM states
// and the byte order of a frame inside the ping-pong buffer.
package adc_capture_writer_pkg;

  localparam int unsigned DATA_BITS             = 16;
  localparam int unsigned DEF_LEADING_BITS      = 1;
  localparam int unsigned DEF_BUFFER_SIZE_BYTES = 1024;
  localparam int unsigned DEF_BUFFER_ADDR_BITS  = $clog2(DEF_BUFFER_SIZE_BYTES);

  localparam int unsigned BYTE_L_LO = 0;
  localparam int unsigned BYTE_L_HI = 1;
  localparam int unsigned BYTE_R_LO = 2;
  localparam int unsigned BYTE_R_HI = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_WAIT_EMPTY = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] left;
    logic [DATA_BITS-1:0] right;
  } frame_t;

  // Byte idx of a frame in buffer order (low byte of each word first).
  function automatic logic [7:0] frame_byte(frame_t f, logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'(BYTE_L_HI): b = f.left[15:8];
      2'(BYTE_R_LO): b = f.right[7:0];
      2'(BYTE_R_HI): b = f.right[15:8];
      default:       b = f.left[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_capture_writer_i2s_deserializer.sv
// I2S receive side: bclk/lrck edge detection, left-word alignment and MSB-first
// shifting; pulses frame_valid once per complete frame.
module adc_capture_writer_i2s_deserializer
  import adc_capture_writer_pkg::*;
#(
  parameter int unsigned LEADING_BITS = DEF_LEADING_BITS,
  parameter int unsigned CHANNELS     = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   capture_en,
  input  logic   bclk,
  input  logic   lrck,
  input  logic   adcdat,
  output logic   frame_valid,
  output frame_t frame
);

  localparam int unsigned LAST_POS = LEADING_BITS + DATA_BITS - 1;
  localparam int unsigned POS_W    = $clog2(LAST_POS + 2);

  logic                 bclk_r, bclk_prev, lrck_r, lrck_last, dat_r;
  logic                 en_prev, aligned;
  logic [POS_W-1:0]     pos_cnt;
  logic [DATA_BITS-1:0] shift_q;

  logic                 bclk_rise, lr_change, en_rise, aligned_now, in_word, word_done;
  logic [POS_W-1:0]     pos;
  logic [DATA_BITS-1:0] shift_next;

  always_comb begin
    bclk_rise   = bclk_r & ~bclk_prev;
    lr_change   = lrck_r ^ lrck_last;
    en_rise     = capture_en & ~en_prev;
    aligned_now = (aligned | (lr_change & ~lrck_r)) & ~en_rise;
    pos         = lr_change ? '0 : pos_cnt;
    in_word     = (pos >= POS_W'(LEADING_BITS)) && (pos <= POS_W'(LAST_POS));
    word_done   = bclk_rise && aligned_now && (pos == POS_W'(LAST_POS));
    shift_next  = {shift_q[DATA_BITS-2:0], dat_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_r      <= 1'b0;
      bclk_prev   <= 1'b0;
      lrck_r      <= 1'b0;
      lrck_last   <= 1'b0;
      dat_r       <= 1'b0;
      en_prev     <= 1'b0;
      aligned     <= 1'b0;
      pos_cnt     <= '0;
      shift_q     <= '0;
      frame_valid <= 1'b0;
      frame       <= '0;
    end else begin
      bclk_r      <= bclk;
      bclk_prev   <= bclk_r;
      lrck_r      <= lrck;
      dat_r       <= adcdat;
      en_prev     <= capture_en;
      frame_valid <= 1'b0;
      if (en_rise) begin
        aligned <= 1'b0;
      end
      if (bclk_rise) begin
        lrck_last <= lrck_r;
        aligned   <= aligned_now;
        pos_cnt   <= (pos == POS_W'(LAST_POS + 1)) ? pos : pos + POS_W'(1);
        if (in_word) begin
          shift_q <= shift_next;
        end
      end
      // Left word completing ends a mono frame; right word ends a stereo frame.
      if (word_done) begin
        if (!lrck_r) begin
          frame.left <= shift_next;
          if (CHANNELS == 1) begin
            frame_valid <= 1'b1;
          end
        end else if (CHANNELS == 2) begin
          frame.right <= shift_next;
          frame_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_capture_writer.sv
// ADC capture writer: deserialises I2S frames and writes them byte-wide into a
// ping-pong buffer, handing full buffers over with the filled/empty handshake.
module adc_capture_writer
  import adc_capture_writer_pkg::*;
#(
  parameter int unsigned LEADING_BITS      = DEF_LEADING_BITS,
  parameter int unsigned CHANNELS          = 2,
  parameter int unsigned BUFFER_SIZE_BYTES = DEF_BUFFER_SIZE_BYTES,
  parameter int unsigned BUFFER_ADDR_BITS  = $clog2(BUFFER_SIZE_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        capture_en_i,
  input  logic                        i2s_bclk_i,
  input  logic                        i2s_lrck_i,
  input  logic                        i2s_adcdat_i,
  output logic                        buff_sel_o,
  output logic [BUFFER_ADDR_BITS-1:0] buff_addr_o,
  output logic [7:0]                  buff_data_o,
  output logic                        buff_we_o,
  output logic                        buff_filled_o,
  input  logic                        buff_filled_ack_i,
  input  logic                        buff_empty_i,
  output logic                        overrun_o
);

  localparam int unsigned FRAME_BYTES = 2 * CHANNELS;
  localparam int unsigned CNT_W       = 3;
  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_ADDR = BUFFER_ADDR_BITS'(BUFFER_SIZE_BYTES - 1);

  wr_state_e                   state_q, state_d;
  frame_t                      frame_in, frame_q, frame_d;
  logic                        frame_valid;
  logic [CNT_W-1:0]            byte_cnt_q, byte_cnt_d;
  logic                        other_free_q, other_free_d;
  logic                        sel_d, we_d, filled_d, overrun_d;
  logic [BUFFER_ADDR_BITS-1:0] addr_d;
  logic [7:0]                  data_d;
  logic                        free_now, complete, swap;

  adc_capture_writer_i2s_deserializer #(
    .LEADING_BITS(LEADING_BITS),
    .CHANNELS    (CHANNELS)
  ) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_en (capture_en_i),
    .bclk       (i2s_bclk_i),
    .lrck       (i2s_lrck_i),
    .adcdat     (i2s_adcdat_i),
    .frame_valid(frame_valid),
    .frame      (frame_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    byte_cnt_d   = byte_cnt_q;
    sel_d        = buff_sel_o;
    addr_d       = buff_addr_o;
    data_d       = buff_data_o;
    we_d         = 1'b0;
    filled_d     = buff_filled_o;
    overrun_d    = overrun_o;
    free_now     = other_free_q | buff_empty_i;
    other_free_d = free_now;
    complete     = 1'b0;
    swap         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_valid && capture_en_i) begin
          frame_d    = frame_in;
          we_d       = 1'b1;
          data_d     = frame_byte(frame_in, 2'(BYTE_L_LO));
          byte_cnt_d = CNT_W'(1);
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (frame_valid) overrun_d = 1'b1;
        if (byte_cnt_q < CNT_W'(FRAME_BYTES)) begin
          we_d       = 1'b1;
          data_d     = frame_byte(frame_q, 2'(byte_cnt_q));
          addr_d     = buff_addr_o + BUFFER_ADDR_BITS'(1);
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end else if (buff_addr_o == LAST_ADDR) begin
          // Last byte of the buffer is on the bus this cycle.
          complete = 1'b1;
          if (free_now) begin
            swap    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_EMPTY;
          end
        end else begin
          addr_d  = buff_addr_o + BUFFER_ADDR_BITS'(1);
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_EMPTY: begin
        if (frame_valid) overrun_d = 1'b1;
        if (free_now) begin
          swap    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (swap) begin
      sel_d        = ~buff_sel_o;
      addr_d       = '0;
      other_free_d = 1'b0;
    end
    if (buff_filled_ack_i) filled_d = 1'b0;
    if (complete)          filled_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q       <= '0;
      byte_cnt_q    <= '0;
      other_free_q  <= 1'b1;
      buff_sel_o    <= 1'b0;
      buff_addr_o   <= '0;
      buff_data_o   <= '0;
      buff_we_o     <= 1'b0;
      buff_filled_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      frame_q       <= frame_d;
      byte_cnt_q    <= byte_cnt_d;
      other_free_q  <= other_free_d;
      buff_sel_o    <= sel_d;
      buff_addr_o   <= addr_d;
      buff_data_o   <= data_d;
      buff_we_o     <= we_d;
      buff_filled_o <= filled_d;
      overrun_o     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_adc_capture_writer.sv
// Randomised I2S stimulus against a buffer-level model of the capture writer.
module tb_adc_capture_writer;

  localparam int unsigned SIZE = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned SLOT = 20;

  logic          clk = 1'b0;
  logic          rst_n, capture_en_i, i2s_bclk_i, i2s_lrck_i, i2s_adcdat_i;
  logic          buff_filled_ack_i, buff_empty_i;
  logic          buff_sel_o, buff_we_o, buff_filled_o, overrun_o;
  logic [AW-1:0] buff_addr_o;
  logic [7:0]    buff_data_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_cyc   = -100;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  obs_cyc[$];

  logic m_sel, m_other_free, m_blocked, m_filled, m_overrun;
  int   m_pos;

  adc_capture_writer #(
    .LEADING_BITS     (1),
    .CHANNELS         (2),
    .BUFFER_SIZE_BYTES(SIZE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .capture_en_i     (capture_en_i),
    .i2s_bclk_i       (i2s_bclk_i),
    .i2s_lrck_i       (i2s_lrck_i),
    .i2s_adcdat_i     (i2s_adcdat_i),
    .buff_sel_o       (buff_sel_o),
    .buff_addr_o      (buff_addr_o),
    .buff_data_o      (buff_data_o),
    .buff_we_o        (buff_we_o),
    .buff_filled_o    (buff_filled_o),
    .buff_filled_ack_i(buff_filled_ack_i),
    .buff_empty_i     (buff_empty_i),
    .overrun_o        (overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (buff_we_o) begin
      obs_q.push_back({buff_sel_o, buff_addr_o, buff_data_o});
      obs_cyc.push_back(cyc);
    end
    if (dut.u_deser.frame_valid) fv_cyc = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(logic lr, logic d);
    i2s_bclk_i   = 1'b0;
    i2s_lrck_i   = lr;
    i2s_adcdat_i = d;
    tick(2);
    i2s_bclk_i = 1'b1;
    tick(2);
  endtask

  // Slot position 0 is the leading bit, 1..16 the word MSB first, then padding.
  task automatic send_slot_part(logic lr, logic [15:0] w, int first, int last);
    for (int p = first; p < last; p++) begin
      if (p >= 1 && p <= 16) send_bit(lr, w[16-p]);
      else                   send_bit(lr, 1'($urandom));
    end
  endtask

  task automatic send_frame(logic [15:0] l, logic [15:0] r);
    send_slot_part(1'b0, l, 0, SLOT);
    send_slot_part(1'b1, r, 0, SLOT);
  endtask

  task automatic preamble();
    send_slot_part(1'b1, 16'($urandom), 0, SLOT);
  endtask

  task automatic model_clear();
    m_sel = 0; m_pos = 0; m_other_free = 1; m_blocked = 0; m_filled = 0; m_overrun = 0;
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    capture_en_i = 1'b1;
    i2s_bclk_i = 1'b0; i2s_lrck_i = 1'b0; i2s_adcdat_i = 1'b0;
    buff_filled_ack_i = 1'b0; buff_empty_i = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    model_clear();
  endtask

  // Buffer-level view: a frame fills four bytes; a full buffer swaps if the
  // other one is free, otherwise the writer blocks and further frames drop.
  task automatic model_frame(logic [15:0] l, logic [15:0] r);
    logic [7:0] b [4];
    wr_t e;
    b = '{l[7:0], l[15:8], r[7:0], r[15:8]};
    if (m_blocked) begin
      m_overrun = 1;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      e.sel = m_sel; e.addr = AW'(m_pos); e.data = b[i];
      exp_q.push_back(e);
      m_pos++;
    end
    if (m_pos == SIZE) begin
      m_filled = 1;
      if (m_other_free) begin
        m_sel = ~m_sel; m_pos = 0; m_other_free = 0;
      end else begin
        m_blocked = 1;
      end
    end
  endtask

  task automatic model_empty();
    if (m_blocked) begin
      m_sel = ~m_sel; m_pos = 0; m_blocked = 0;
    end else begin
      m_other_free = 1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] l, r;
    rst_n = 1'b0;
    capture_en_i = 1'b1;
    i2s_bclk_i = 1'b0; i2s_lrck_i = 1'b0; i2s_adcdat_i = 1'b0;
    buff_filled_ack_i = 1'b0; buff_empty_i = 1'b0;
    #1;
    n_checks++;
    if ({buff_sel_o, buff_addr_o, buff_data_o, buff_we_o, buff_filled_o, overrun_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_asserted: got sel=%b addr=%0d data=%02h we=%b filled=%b ovr=%b, all must be 0",
               buff_sel_o, buff_addr_o, buff_data_o, buff_we_o, buff_filled_o, overrun_o);
    end
    tick(3);
    rst_n = 1'b1;
    model_clear();
    tick(10);
    n_checks++;
    if ({buff_sel_o, buff_addr_o, buff_data_o, buff_we_o, buff_filled_o, overrun_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_released: got sel=%b addr=%0d data=%02h we=%b filled=%b ovr=%b, all must be 0",
               buff_sel_o, buff_addr_o, buff_data_o, buff_we_o, buff_filled_o, overrun_o);
    end
    // lrck starts low, so this left slot has no falling edge and must be ignored.
    send_frame(16'($urandom), 16'($urandom));
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_unaligned: got %0d writes, required 0", obs_q.size());
    end
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r);
    model_frame(l, r);
    tick(4);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_first_frame count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_first_frame[%0d]: got %0b/%0d/%02h, required %0b/%0d/%02h", i,
                 obs_q[i].sel, obs_q[i].addr, obs_q[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    preamble();
    send_frame(16'h1234, 16'hABCD);
    model_frame(16'h1234, 16'hABCD);
    tick(4);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_frame count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_frame[%0d]: got %0b/%0d/%02h, required %0b/%0d/%02h", i,
                 obs_q[i].sel, obs_q[i].addr, obs_q[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
    if (obs_cyc.size() == 4) begin
      n_checks++;
      if (obs_cyc[0] != fv_cyc + 1) begin
        n_fail++;
        $display("FAIL single_frame latency: first we at cycle %0d, required %0d", obs_cyc[0], fv_cyc + 1);
      end
      n_checks++;
      if (obs_cyc[3] - obs_cyc[0] != 3) begin
        n_fail++;
        $display("FAIL single_frame burst: 4 bytes span %0d cycles, required 3", obs_cyc[3] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_fill_swap();
    logic [15:0] l, r;
    do_reset();
    preamble();
    for (int f = 0; f < 4; f++) begin
      l = 16'($urandom); r = 16'($urandom);
      send_frame(l, r);
      model_frame(l, r);
    end
    tick(4);
    n_checks++;
    if (buff_filled_o !== m_filled) begin
      n_fail++;
      $display("FAIL fill_swap filled: got %b, required %b", buff_filled_o, m_filled);
    end
    n_checks++;
    if (buff_sel_o !== m_sel) begin
      n_fail++;
      $display("FAIL fill_swap sel: got %b, required %b", buff_sel_o, m_sel);
    end
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r);
    model_frame(l, r);
    buff_filled_ack_i = 1'b1;
    tick(1);
    buff_filled_ack_i = 1'b0;
    m_filled = 0;
    tick(2);
    n_checks++;
    if (buff_filled_o !== m_filled) begin
      n_fail++;
      $display("FAIL fill_swap ack: got filled=%b, required %b", buff_filled_o, m_filled);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL fill_swap count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fill_swap[%0d]: got %0b/%0d/%02h, required %0b/%0d/%02h", i,
                 obs_q[i].sel, obs_q[i].addr, obs_q[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] l, r;
    do_reset();
    preamble();
    for (int f = 0; f < 9; f++) begin
      l = 16'($urandom); r = 16'($urandom);
      send_frame(l, r);
      model_frame(l, r);
    end
    tick(4);
    n_checks++;
    if (overrun_o !== m_overrun) begin
      n_fail++;
      $display("FAIL overrun flag: got %b, required %b", overrun_o, m_overrun);
    end
    buff_empty_i = 1'b1;
    tick(1);
    buff_empty_i = 1'b0;
    model_empty();
    tick(3);
    n_checks++;
    if ({buff_sel_o, buff_addr_o} !== {m_sel, AW'(m_pos)}) begin
      n_fail++;
      $display("FAIL overrun release: got sel=%b addr=%0d, required sel=%b addr=%0d",
               buff_sel_o, buff_addr_o, m_sel, m_pos);
    end
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r);
    model_frame(l, r);
    tick(4);
    n_checks++;
    if (overrun_o !== m_overrun) begin
      n_fail++;
      $display("FAIL overrun sticky: got %b, required %b", overrun_o, m_overrun);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL overrun count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL overrun[%0d]: got %0b/%0d/%02h, required %0b/%0d/%02h", i,
                 obs_q[i].sel, obs_q[i].addr, obs_q[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_empty_same_cycle();
    logic [15:0] l, r;
    bit found;
    do_reset();
    preamble();
    for (int f = 0; f < 7; f++) begin
      l = 16'($urandom); r = 16'($urandom);
      send_frame(l, r);
      model_frame(l, r);
    end
    l = 16'($urandom); r = 16'($urandom);
    found = 0;
    fork
      send_frame(l, r);
      for (int k = 0; k < 300 && !found; k++) begin
        @(negedge clk);
        if (buff_we_o && buff_sel_o && buff_addr_o == AW'(SIZE - 1)) begin
          buff_empty_i = 1'b1;
          found = 1;
          @(negedge clk);
          buff_empty_i = 1'b0;
        end
      end
    join
    model_empty();
    model_frame(l, r);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL same_cycle: byte @%0d of buffer 1 never seen, required once", SIZE - 1);
    end
    tick(2);
    n_checks++;
    if ({buff_sel_o, overrun_o} !== {m_sel, m_overrun}) begin
      n_fail++;
      $display("FAIL same_cycle swap: got sel=%b ovr=%b, required sel=%b ovr=%b",
               buff_sel_o, overrun_o, m_sel, m_overrun);
    end
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r);
    model_frame(l, r);
    tick(4);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL same_cycle count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL same_cycle[%0d]: got %0b/%0d/%02h, required %0b/%0d/%02h", i,
                 obs_q[i].sel, obs_q[i].addr, obs_q[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] l, r;
    do_reset();
    preamble();
    for (int f = 0; f < 5; f++) begin
      l = 16'($urandom); r = 16'($urandom);
      send_frame(l, r);
      model_frame(l, r);
    end
    l = 16'($urandom); r = 16'($urandom);
    send_slot_part(1'b0, l, 0, SLOT);
    send_slot_part(1'b1, r, 0, 9);
    n_checks++;
    if ({buff_sel_o, buff_addr_o, buff_filled_o} !== {m_sel, AW'(m_pos), m_filled}) begin
      n_fail++;
      $display("FAIL midframe pre-reset: got sel=%b addr=%0d filled=%b, required sel=%b addr=%0d filled=%b",
               buff_sel_o, buff_addr_o, buff_filled_o, m_sel, m_pos, m_filled);
    end
    // Ninth bit of the right word: reset lands between clock edges.
    i2s_bclk_i = 1'b0; i2s_adcdat_i = r[7];
    tick(2);
    i2s_bclk_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({buff_sel_o, buff_addr_o, buff_data_o, buff_we_o, buff_filled_o, overrun_o} !== '0) begin
      n_fail++;
      $display("FAIL midframe async_reset: got sel=%b addr=%0d data=%02h we=%b filled=%b ovr=%b, all must be 0",
               buff_sel_o, buff_addr_o, buff_data_o, buff_we_o, buff_filled_o, overrun_o);
    end
    tick(1);
    rst_n = 1'b1;
    model_clear();
    tick(1);
    send_slot_part(1'b1, r, 10, SLOT);
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r);
    model_frame(l, r);
    tick(4);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midframe count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midframe[%0d]: got %0b/%0d/%02h, required %0b/%0d/%02h", i,
                 obs_q[i].sel, obs_q[i].addr, obs_q[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_capture_disable();
    logic [15:0] l, r;
    do_reset();
    preamble();
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r);
    model_frame(l, r);
    capture_en_i = 1'b0;
    send_frame(16'($urandom), 16'($urandom));
    // Enable rises mid left word: that frame is discarded until realignment.
    l = 16'($urandom); r = 16'($urandom);
    send_slot_part(1'b0, l, 0, 3);
    capture_en_i = 1'b1;
    send_slot_part(1'b0, l, 3, SLOT);
    send_slot_part(1'b1, r, 0, SLOT);
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r);
    model_frame(l, r);
    tick(4);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL capture_en count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL capture_en[%0d]: got %0b/%0d/%02h, required %0b/%0d/%02h", i,
                 obs_q[i].sel, obs_q[i].addr, obs_q[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_swap();
    test_overrun();
    test_empty_same_cycle();
    test_reset_midframe();
    test_capture_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
